mem_access_stage: RTL
=====================

# mem_access_stage

Parametrised MIPS memory-access stage: byte/halfword/word loads (signed and unsigned) and byte-enabled stores against an internal data memory, with a configurable read latency and the MEM/WB pipeline register folded in. Sits between the EX/MEM register and the write-back stage. Drives a stall back to the hazard unit while a multi-cycle load is outstanding, and flags misaligned accesses.

## Interface
- DATA_WIDTH, 32, datapath width; fixed at 32 for byte-lane logic, parameterised for port sizing
- ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH words
- REG_ADDR_WIDTH, 5, destination register index width
- MEM_LATENCY, 1, load latency in cycles (1..4); stores always take 1 cycle

Ports:
- clk  in  1  rising-edge clock; one clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  instruction present from EX/MEM
- ex_mem_read / ex_mem_write  in  1 each  load / store request (never both)
- ex_mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- ex_mem_unsigned  in  1  zero-extend loads (LBU/LHU)
- ex_alu_result  in  DATA_WIDTH  byte address, or ALU result for non-memory ops
- ex_store_data  in  DATA_WIDTH  store data, right-aligned
- ex_reg_write, ex_mem_to_reg  in  1 each  WB control
- ex_rd  in  REG_ADDR_WIDTH  destination register
- flush  in  1  kill the instruction in this stage
- mem_stall  out  1  upstream must hold ex_* stable
- misalign_exc  out  1  one-cycle pulse, misaligned access
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each
- wb_rd  out  REG_ADDR_WIDTH
- wb_read_data, wb_alu_result  out  DATA_WIDTH

## Operation
- Word index = ex_alu_result[ADDR_WIDTH+1:2]; upper address bits ignored (wrap). Little-endian lanes: byte n at bits 8n+7:8n.
- Stores: byte enables from size and addr[1:0]; data replicated into the selected lane(s); committed at the accepting edge.
- Loads: lane selected by addr[1:0]; sign-extend from bit 7/15 unless ex_mem_unsigned.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. No memory write, wb_valid=0, misalign_exc=1 on the next cycle.
- FSM IDLE/BUSY. IDLE: load with MEM_LATENCY>1 moves to BUSY, counter = MEM_LATENCY-1. BUSY: counter decrements; on 1→0, result loads into MEM/WB and FSM returns to IDLE.
- mem_stall = (IDLE and valid aligned load and MEM_LATENCY>1) or (BUSY and counter>1). Combinational.
- MEM/WB receives a bubble (all wb_* 0) on every stalled cycle.
- flush: MEM/WB loads a bubble next edge, store suppressed, BUSY aborts to IDLE, misalign_exc suppressed. flush has priority over all other events.
- reset: all outputs 0, FSM IDLE, counter 0. Memory contents not cleared.
- Non-memory valid instructions pass through in 1 cycle with wb_read_data=0.

## Timing
- Non-memory op or store accepted at cycle N: wb_* valid at N+1.
- Load with latency L accepted at cycle N: mem_stall high during N..N+L-2; wb_read_data valid at N+L. L=1 never stalls.
- Store at N followed by a load to the same word at N+1 returns the new data (write-first through the array).
- reset asserted mid-BUSY: IDLE and outputs 0 after that edge; the pending load is lost.

## Structure
- Shared package/header mips_mem_defs: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encodings.
- One sub-module: data_memory_be, a synchronous RAM with 4-bit byte-enable write and registered read, parameterised by ADDR_WIDTH. Latency counter, lane/extension logic, and MEM/WB register stay in mem_access_stage.

## Test plan
- SW 0xDEADBEEF @0x10, then LB/LBU @0x13 → 0xFFFFFFDE / 0x000000DE; LH @0x10 → 0xFFFFBEEF.
- SB 0x5A @0x21 over word 0x00000000, then LW @0x20 → 0x00005A00.
- LH @0x01 → misalign_exc pulse, wb_valid=0, memory unchanged; SW @0x02 likewise.
- MEM_LATENCY=3, LW @0x10 at cycle N → mem_stall high at N and N+1, wb_valid=1 with data at N+3.
- MEM_LATENCY=3, flush at N+1 of a load → mem_stall low at N+2, no wb_valid; SB with flush → no write.
- reset during BUSY → all outputs 0 next cycle; a following LW completes normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared MIPS memory-access definitions: access-size encodings, the load
// FSM state type and the byte-lane helpers used by mem_access_stage.
// No ports; imported with `import mips_mem_defs::*;`.
package mips_mem_defs;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 is also treated as word

  localparam int unsigned LAT_CNT_W = 3;    // holds MEM_LATENCY-1 for latency up to 4

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data arrives right-aligned; replicate it so every lane the
  // byte enables may select carries the right bits.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle between the EX/MEM register, the memory-access stage and write-back.
// master: upstream/driver side (drives ex_* and flush, sees stall and wb_*).
// slave : the memory-access stage (consumes ex_* and flush, drives the rest).
interface mem_access_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      ex_valid;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [1:0]                ex_mem_size;
  logic                      ex_mem_unsigned;
  logic [DATA_WIDTH-1:0]     ex_alu_result;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic                      ex_reg_write;
  logic                      ex_mem_to_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      flush;

  logic                      mem_stall;
  logic                      misalign_exc;
  logic                      wb_valid;
  logic                      wb_reg_write;
  logic                      wb_mem_to_reg;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_read_data;
  logic [DATA_WIDTH-1:0]     wb_alu_result;

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_mem_size, ex_mem_unsigned,
           ex_alu_result, ex_store_data, ex_reg_write, ex_mem_to_reg, ex_rd, flush,
    input  mem_stall, misalign_exc, wb_valid, wb_reg_write, wb_mem_to_reg,
           wb_rd, wb_read_data, wb_alu_result
  );

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_mem_size, ex_mem_unsigned,
           ex_alu_result, ex_store_data, ex_reg_write, ex_mem_to_reg, ex_rd, flush,
    output mem_stall, misalign_exc, wb_valid, wb_reg_write, wb_mem_to_reg,
           wb_rd, wb_read_data, wb_alu_result
  );
endinterface

// File: rtl/data_memory_be.sv
// Single-port synchronous data RAM, 32-bit words, byte-enabled write and
// registered read. A read and write in the same cycle returns the merged
// (newly written) word.
// Ports: clk; we/be/wdata write controls; addr word index; re loads rdata.
module data_memory_be #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  output logic [31:0]           rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];
  logic [31:0] merged;

  always_comb begin
    merged = mem[addr];
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= merged;
  end
endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage with the MEM/WB register folded in.
// Ports: clk, reset (sync, active-high); bus (slave) carries the ex_* inputs
// and flush from EX/MEM, and mem_stall, misalign_exc and wb_* outputs.
// Loads take MEM_LATENCY cycles (stalling upstream while pending), stores and
// non-memory ops take one. Misaligned accesses are dropped and flagged.
module mem_access_stage
  import mips_mem_defs::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_LATENCY    = 1
) (
  input logic          clk,
  input logic          reset,
  mem_access_stage_if.slave bus
);
  localparam logic                 MULTI_CYCLE = (MEM_LATENCY > 1);
  localparam logic [LAT_CNT_W-1:0] CNT_INIT    = LAT_CNT_W'(MEM_LATENCY - 1);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE     = LAT_CNT_W'(1);

  mem_state_e                state;
  logic [LAT_CNT_W-1:0]      cnt;

  logic [ADDR_WIDTH-1:0]     word_idx;
  logic [1:0]                byte_off;
  logic                      misaligned, mem_op, idle;
  logic                      load_req, store_req, alu_req;
  logic                      load_done, store_commit, wb_accept, mis_issue;
  logic [3:0]                ram_be;
  logic [31:0]               ram_wdata, ram_rdata;

  logic                      wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0]     wb_alu_q;
  logic                      wb_load_q, wb_uns_q, misalign_q;
  logic [1:0]                wb_size_q, wb_off_q;

  always_comb begin
    word_idx  = bus.ex_alu_result[ADDR_WIDTH+1:2];
    byte_off  = bus.ex_alu_result[1:0];
    misaligned = is_misaligned(bus.ex_mem_size, byte_off);
    mem_op    = bus.ex_mem_read | bus.ex_mem_write;
    idle      = (state == ST_IDLE);
    load_req  = bus.ex_valid & bus.ex_mem_read  & ~misaligned;
    store_req = bus.ex_valid & bus.ex_mem_write & ~misaligned;
    alu_req   = bus.ex_valid & ~mem_op;

    // A load completes either immediately (latency 1) or on the BUSY cycle
    // where the counter steps 1->0; upstream holds ex_* stable until then.
    load_done    = ~bus.flush & ((idle & load_req & ~MULTI_CYCLE) |
                                 ((state == ST_BUSY) & (cnt == CNT_ONE)));
    store_commit = ~bus.flush & idle & store_req;
    wb_accept    = load_done | store_commit | (~bus.flush & idle & alu_req);
    mis_issue    = ~bus.flush & idle & bus.ex_valid & mem_op & misaligned;

    ram_be    = byte_enables(bus.ex_mem_size, byte_off);
    ram_wdata = store_lanes(bus.ex_mem_size, bus.ex_store_data);

    bus.mem_stall = (idle & load_req & MULTI_CYCLE) |
                    ((state == ST_BUSY) & (cnt > CNT_ONE));
  end

  data_memory_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dmem (
    .clk   (clk),
    .we    (store_commit),
    .be    (ram_be),
    .addr  (word_idx),
    .wdata (ram_wdata),
    .re    (load_done),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      misalign_q      <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= '0;
      wb_alu_q        <= '0;
      wb_load_q       <= 1'b0;
      wb_size_q       <= '0;
      wb_off_q        <= '0;
      wb_uns_q        <= 1'b0;
    end else begin
      misalign_q <= mis_issue;

      if (wb_accept) begin
        wb_valid_q      <= 1'b1;
        wb_reg_write_q  <= bus.ex_reg_write;
        wb_mem_to_reg_q <= bus.ex_mem_to_reg;
        wb_rd_q         <= bus.ex_rd;
        wb_alu_q        <= bus.ex_alu_result;
        wb_load_q       <= load_done;
        wb_size_q       <= bus.ex_mem_size;
        wb_off_q        <= byte_off;
        wb_uns_q        <= bus.ex_mem_unsigned;
      end else begin
        wb_valid_q      <= 1'b0;
        wb_reg_write_q  <= 1'b0;
        wb_mem_to_reg_q <= 1'b0;
        wb_rd_q         <= '0;
        wb_alu_q        <= '0;
        wb_load_q       <= 1'b0;
        wb_size_q       <= '0;
        wb_off_q        <= '0;
        wb_uns_q        <= 1'b0;
      end

      if (bus.flush) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (load_req && MULTI_CYCLE) begin
              state <= ST_BUSY;
              cnt   <= CNT_INIT;
            end
          end
          ST_BUSY: begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // The RAM read register doubles as the MEM/WB data register; lane select
  // and extension are applied on its output using the registered offsets.
  assign bus.wb_read_data  = wb_load_q ? DATA_WIDTH'(load_extend(ram_rdata, wb_size_q, wb_off_q, wb_uns_q))
                                       : '0;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_reg_write  = wb_reg_write_q;
  assign bus.wb_mem_to_reg = wb_mem_to_reg_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_alu_result = wb_alu_q;
  assign bus.misalign_exc  = misalign_q;
endmodule
